// File: rtl/arbiter_v2.sv
// arbiter_v2: grants one bus master at a time, using fixed-priority or round-robin
// arbitration. It then sequences the address setup, the target handshake and the
// transfer-ending strobe, and flags a timeout when the target never answers.
module arbiter_v2 #(
  parameter int unsigned DEVICE_MAX_NUMBER = 4,
  parameter int unsigned CLK_MAX_TIMEOUT   = 12,
  parameter int unsigned ADDR_SETUP        = 2,
  parameter int unsigned ARB_MODE          = 0
) (
  input  logic                                 clock,
  input  logic                                 nreset,
  input  logic [DEVICE_MAX_NUMBER-1:0]         barq,
  output logic [DEVICE_MAX_NUMBER-1:0]         bagd,
  output logic [$clog2(DEVICE_MAX_NUMBER)-1:0] grant_idx,
  output logic                                 busy,
  output logic                                 addressvalid,
  input  logic                                 TargetReady,
  output logic                                 DataStrobe,
  output logic                                 Error
);

  localparam int unsigned N      = DEVICE_MAX_NUMBER;
  localparam int unsigned IdxW   = $clog2(DEVICE_MAX_NUMBER);
  localparam int unsigned ToW    = $clog2(CLK_MAX_TIMEOUT + 1);
  localparam int unsigned SetupW = $clog2(ADDR_SETUP + 1);

  typedef enum logic [2:0] {
    StIdle   = 3'd0,
    StSetup  = 3'd1,
    StWait   = 3'd2,
    StStrobe = 3'd3,
    StEnd    = 3'd4
  } stateT;

  stateT             state;
  logic [IdxW-1:0]   rrPtr;
  logic [ToW-1:0]    timeoutCnt;
  logic [SetupW-1:0] setupCnt;

  logic [IdxW-1:0]   winner;
  logic [IdxW-1:0]   cand;
  logic              found;
  logic [IdxW-1:0]   nextPtr;
  logic [N-1:0]      winnerOneHot;

  // Pick the first requester: from index 0 (fixed) or from the rotating pointer (round-robin)
  always_comb begin
    winner = '0;
    found  = 1'b0;
    cand   = '0;
    for (int unsigned i = 0; i < N; i++) begin
      if (ARB_MODE == 1) cand = IdxW'((32'(rrPtr) + i) % N);
      else               cand = IdxW'(i);
      if (!found && barq[cand]) begin
        found  = 1'b1;
        winner = cand;
      end
    end
  end

  // Round-robin pointer moves just past the winner, wrapping at the last master
  always_comb begin
    nextPtr = (32'(winner) == N - 1) ? '0 : winner + IdxW'(1);
  end

  // One-hot form of the winning index for the grant vector
  always_comb begin
    winnerOneHot         = '0;
    winnerOneHot[winner] = 1'b1;
  end

  // Transfer sequencer: the state, the counters and all registered outputs
  always_ff @(posedge clock or negedge nreset) begin
    if (!nreset) begin
      state        <= StIdle;
      rrPtr        <= '0;
      timeoutCnt   <= '0;
      setupCnt     <= '0;
      bagd         <= '0;
      grant_idx    <= '0;
      busy         <= 1'b0;
      addressvalid <= 1'b0;
      DataStrobe   <= 1'b0;
      Error        <= 1'b0;
    end else begin
      case (state)
        StIdle: begin
          DataStrobe <= 1'b0;
          Error      <= 1'b0;
          if (|barq) begin
            bagd      <= winnerOneHot;
            grant_idx <= winner;
            busy      <= 1'b1;
            setupCnt  <= '0;
            state     <= StSetup;
            if (ARB_MODE == 1) rrPtr <= nextPtr;
          end
        end
        StSetup: begin
          // Give the address mux ADDR_SETUP cycles to settle before the decode window opens
          if (setupCnt == SetupW'(ADDR_SETUP - 1)) begin
            addressvalid <= 1'b1;
            timeoutCnt   <= '0;
            state        <= StWait;
          end else begin
            setupCnt <= setupCnt + SetupW'(1);
          end
        end
        StWait: begin
          // A ready on the final allowed cycle still counts as a normal completion
          if (TargetReady) begin
            DataStrobe <= 1'b1;
            state      <= StStrobe;
          end else if (timeoutCnt == ToW'(CLK_MAX_TIMEOUT - 1)) begin
            DataStrobe <= 1'b1;
            Error      <= 1'b1;
            state      <= StStrobe;
          end else begin
            timeoutCnt <= timeoutCnt + ToW'(1);
          end
        end
        StStrobe: begin
          DataStrobe   <= 1'b0;
          Error        <= 1'b0;
          bagd         <= '0;
          grant_idx    <= '0;
          busy         <= 1'b0;
          addressvalid <= 1'b0;
          timeoutCnt   <= '0;
          state        <= StEnd;
        end
        StEnd: begin
          // Holds the bus idle for one cycle between consecutive grants
          state <= StIdle;
        end
        default: begin
          state <= StIdle;
        end
      endcase
    end
  end

  // Structural invariants of the grant and strobe outputs
  assert property (@(posedge clock) disable iff (!nreset) $onehot0(bagd));
  assert property (@(posedge clock) disable iff (!nreset) addressvalid |-> (|bagd));
  assert property (@(posedge clock) disable iff (!nreset) DataStrobe |=> !DataStrobe);
  assert property (@(posedge clock) disable iff (!nreset) Error |-> DataStrobe);

endmodule
